gate_truth_table_checker: RTL and testbench
===========================================

// Module: gate_truth_table_checker
// PURPOSE
//  Sequencer for a 2-input logic-gate datapath (AND_gate or any sibling gate).
//  - Drives the gate's two inputs through all four combinations.
//  - Waits a programmable settle time for each combination, then samples the gate output.
//  - Compares the captured truth table against an expected table and reports pass/fail.
//  - Sits beside the gate under check as its stimulus/checker controller.
// PARAMETERS
//  EXPECTED       4'b1000  expected truth table; bit i = O for {A,B}=i (AND=1000, OR=1110)
//  SETTLE_CYCLES  2        cycles each vector is held before sampling; legal 1..255
// PORTS
//  clk        in   1  rising-edge clock
//  reset      in   1  synchronous, active-high reset
//  start      in   1  run request; sampled only in IDLE
//  gate_a     out  1  drives gate input A
//  gate_b     out  1  drives gate input B
//  gate_o     in   1  gate output under check
//  busy       out  1  high from the cycle after start is accepted through the DONE cycle
//  done       out  1  one-cycle pulse; results valid from this cycle
//  pass       out  1  result_tt == EXPECTED; held until the next accepted start
//  fail_mask  out  4  result_tt ^ EXPECTED; held until the next accepted start
//  result_tt  out  4  captured truth table; bit i written at vector i's SAMPLE
// BEHAVIOUR
//  Reset values: all outputs 0; state = IDLE; vector index idx = 0; settle counter = 0.
//  Registering: all outputs are registered.
//  Input drive: gate_a = idx[1], gate_b = idx[0] in SETTLE/SAMPLE; both 0 in IDLE and DONE.
//  FSM transitions:
//   IDLE   : start=1 -> SETTLE; idx=0; cnt=0; result_tt, pass, fail_mask cleared.
//            start=0 -> stay in IDLE.
//   SETTLE : cnt increments each cycle; at cnt == SETTLE_CYCLES-1 -> SAMPLE.
//   SAMPLE : result_tt[idx] <= gate_o.
//            idx == 3 -> DONE.
//            idx < 3  -> idx+1, cnt=0, SETTLE.
//   DONE   : done=1; pass and fail_mask loaded from the final table; -> IDLE.
//  Timing: each vector occupies SETTLE_CYCLES+1 cycles.
//   Start accepted in cycle 0 -> done=1 in cycle 1 + 4*(SETTLE_CYCLES+1).
//   Default: done in cycle 13.
//  Boundaries:
//   - start while busy is ignored; no queuing.
//   - start held high: back-to-back runs with exactly one IDLE cycle between DONE and the next SETTLE.
//   - reset mid-run: next cycle all outputs 0, state IDLE, partial results discarded.
//   - gate_o is sampled only in SAMPLE; changes at any other time have no effect.
//   - pass and fail_mask are not updated before DONE.
// CONFIGURATION
//  Macro: GATE_TT_CHECK_ERRCNT_EN
//   Defined: adds output err_count [7:0], reset 0.
//    - Increments in the DONE cycle when pass would be 0.
//    - Saturates at 255.
//    - Not cleared by start; only reset clears it.
//   Undefined: err_count port and its logic are absent; all other behaviour identical.
// TESTING
//  T1: defaults, AND model on gate_o, pulse start ->
//      done in cycle 13; result_tt=1000, pass=1, fail_mask=0000.
//  T2: OR model on gate_o ->
//      result_tt=1110, pass=0, fail_mask=0110.
//  T3: start pulsed again at cycles 3 and 8 of a run ->
//      ignored; single done in cycle 13.
//  T4: reset asserted in cycle 6 ->
//      cycle 7: all outputs 0, busy=0; a fresh start gives a correct, full-length run.
//  T5: SETTLE_CYCLES=1, AND model ->
//      done in cycle 9; gate_a/gate_b sequence 00,01,10,11, each held 2 cycles.
//  T6: GATE_TT_CHECK_ERRCNT_EN defined, two OR-model runs then one AND-model run ->
//      err_count = 1, then 2, then stays 2.

Source files
------------

// File: rtl/gate_truth_table_checker.sv
// Stimulus/checker sequencer for a 2-input gate: walks {A,B} through 00..11,
// captures the gate output per vector and compares against EXPECTED.
// Optional feature macro: GATE_TT_CHECK_ERRCNT_EN (adds saturating err_count).
module gate_truth_table_checker #(
    parameter logic [3:0] EXPECTED      = 4'b1000,
    parameter int         SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       gate_a,
    output logic       gate_b,
    input  logic       gate_o,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_mask,
`ifdef GATE_TT_CHECK_ERRCNT_EN
    output logic [7:0] err_count,
`endif
    output logic [3:0] result_tt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    localparam logic [7:0] LP_CNT_LAST = 8'(SETTLE_CYCLES - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_idx;
    logic [1:0] w_idx_nxt;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nxt;
    logic [3:0] r_result;
    logic [3:0] w_result_nxt;
    logic       r_pass;
    logic       w_pass_nxt;
    logic [3:0] r_fmask;
    logic [3:0] w_fmask_nxt;
    logic       r_gate_a;
    logic       r_gate_b;
    logic       r_busy;
    logic       r_done;
    logic       w_drive;
    logic       w_final;

    // Next-state, vector index, settle counter and captured results
    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_cnt_nxt    = r_cnt;
        w_result_nxt = r_result;
        w_pass_nxt   = r_pass;
        w_fmask_nxt  = r_fmask;
        w_final      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt  = S_SETTLE;
                    w_idx_nxt    = 2'd0;
                    w_cnt_nxt    = 8'd0;
                    w_result_nxt = 4'b0000;
                    w_pass_nxt   = 1'b0;
                    w_fmask_nxt  = 4'b0000;
                end
            end
            S_SETTLE: begin
                if (r_cnt == LP_CNT_LAST) begin
                    w_state_nxt = S_SAMPLE;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            S_SAMPLE: begin
                w_result_nxt[r_idx] = gate_o;
                if (r_idx == 2'd3) begin
                    w_state_nxt = S_DONE;
                    w_final     = 1'b1;
                    w_pass_nxt  = (w_result_nxt == EXPECTED);
                    w_fmask_nxt = w_result_nxt ^ EXPECTED;
                end else begin
                    w_state_nxt = S_SETTLE;
                    w_idx_nxt   = r_idx + 2'd1;
                    w_cnt_nxt   = 8'd0;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_idx_nxt   = 2'd0;
                w_cnt_nxt   = 8'd0;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Gate inputs follow the index only while a vector is being applied
    assign w_drive = (w_state_nxt == S_SETTLE) ||
                     (w_state_nxt == S_SAMPLE);

    // State register and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_idx    <= 2'd0;
            r_cnt    <= 8'd0;
            r_result <= 4'b0000;
            r_pass   <= 1'b0;
            r_fmask  <= 4'b0000;
            r_gate_a <= 1'b0;
            r_gate_b <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_idx    <= w_idx_nxt;
            r_cnt    <= w_cnt_nxt;
            r_result <= w_result_nxt;
            r_pass   <= w_pass_nxt;
            r_fmask  <= w_fmask_nxt;
            r_gate_a <= w_drive & w_idx_nxt[1];
            r_gate_b <= w_drive & w_idx_nxt[0];
            r_busy   <= (w_state_nxt != S_IDLE);
            r_done   <= (w_state_nxt == S_DONE);
        end
    end

`ifdef GATE_TT_CHECK_ERRCNT_EN
    logic [7:0] r_err;

    // Failed-run counter, saturating, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 8'd0;
        end else if (w_final && !w_pass_nxt && (r_err != 8'hFF)) begin
            r_err <= r_err + 8'd1;
        end
    end

    assign err_count = r_err;
`endif

    assign gate_a    = r_gate_a;
    assign gate_b    = r_gate_b;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign fail_mask = r_fmask;
    assign result_tt = r_result;

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Directed bench for gate_truth_table_checker: AND/OR gate models,
// ignored starts, mid-run reset, held start and a 1-cycle settle instance.
module tb_gate_truth_table_checker;

    logic       clk;
    logic       reset;
    logic       start;
    logic       start2;
    logic       a1, b1, o1;
    logic       busy1, done1, pass1;
    logic [3:0] fm1, rt1;
    logic       a2, b2, o2;
    logic       busy2, done2, pass2;
    logic [3:0] fm2, rt2;
`ifdef GATE_TT_CHECK_ERRCNT_EN
    logic [7:0] ec1, ec2;
`endif

    int mode;
    logic inv;
    int n_chk;
    int n_err;

    // mode 0: AND, 1: OR, 2: AND corrupted outside the sample cycles
    assign o1 = (mode == 1) ? (a1 | b1) : ((a1 & b1) ^ inv);
    assign o2 = a2 & b2;

    gate_truth_table_checker #(
        .EXPECTED(4'b1000),
        .SETTLE_CYCLES(2)
    ) u_dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .gate_a(a1),
        .gate_b(b1),
        .gate_o(o1),
        .busy(busy1),
        .done(done1),
        .pass(pass1),
        .fail_mask(fm1),
`ifdef GATE_TT_CHECK_ERRCNT_EN
        .err_count(ec1),
`endif
        .result_tt(rt1)
    );

    gate_truth_table_checker #(
        .EXPECTED(4'b1000),
        .SETTLE_CYCLES(1)
    ) u_dut1 (
        .clk(clk),
        .reset(reset),
        .start(start2),
        .gate_a(a2),
        .gate_b(b2),
        .gate_o(o2),
        .busy(busy2),
        .done(done2),
        .pass(pass2),
        .fail_mask(fm2),
`ifdef GATE_TT_CHECK_ERRCNT_EN
        .err_count(ec2),
`endif
        .result_tt(rt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Pulse (or hold) start in cycle 0, step until done; dcyc = done cycle
    task automatic run1(input bit pulses, input bit hold, output int dcyc);
        @(posedge clk); #1;
        start = 1'b1;
        dcyc = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            start = hold | (pulses & ((k == 3) || (k == 8)));
            inv = (mode == 2) && ((k % 3) != 0);
            if (k == 1) begin
                check("busy_c1", 32'(busy1), 32'd1);
                check("rt_clr", 32'(rt1), 32'd0);
                check("pass_clr", 32'(pass1), 32'd0);
                check("ab_c1", 32'({a1, b1}), 32'd0);
            end
            if (k == 12) begin
                check("pass_early", 32'(pass1), 32'd0);
                check("fm_early", 32'(fm1), 32'd0);
                check("done_early", 32'(done1), 32'd0);
                check("ab_c12", 32'({a1, b1}), 32'd3);
            end
            if (done1) begin
                dcyc = k;
                break;
            end
        end
        inv = 1'b0;
    endtask

    task automatic final1(input string tag, input int dcyc,
                          input logic [3:0] rt, input logic ps,
                          input logic [3:0] fm);
        check({tag, "_cyc"}, 32'(dcyc), 32'd13);
        check({tag, "_rt"}, 32'(rt1), 32'(rt));
        check({tag, "_pass"}, 32'(pass1), 32'(ps));
        check({tag, "_fm"}, 32'(fm1), 32'(fm));
        check({tag, "_busy"}, 32'(busy1), 32'd1);
        check({tag, "_ab"}, 32'({a1, b1}), 32'd0);
    endtask

    int d;
    int ndone;
    logic [1:0] ab_exp;

    initial begin
        n_chk = 0;
        n_err = 0;
        mode = 0;
        inv = 1'b0;
        reset = 1'b1;
        start = 1'b0;
        start2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy1), 32'd0);
        check("rst_done", 32'(done1), 32'd0);
        check("rst_pass", 32'(pass1), 32'd0);
        check("rst_fm", 32'(fm1), 32'd0);
        check("rst_rt", 32'(rt1), 32'd0);
        check("rst_ab", 32'({a1, b1}), 32'd0);
`ifdef GATE_TT_CHECK_ERRCNT_EN
        check("rst_ec", 32'(ec1), 32'd0);
`endif
        reset = 1'b0;

        // T1: AND gate
        mode = 0;
        run1(1'b0, 1'b0, d);
        final1("t1", d, 4'b1000, 1'b1, 4'b0000);
        @(posedge clk); #1;
        check("t1_done_pulse", 32'(done1), 32'd0);
        check("t1_idle_busy", 32'(busy1), 32'd0);
        check("t1_pass_held", 32'(pass1), 32'd1);

        // T2: OR gate, twice
        mode = 1;
        run1(1'b0, 1'b0, d);
        final1("t2", d, 4'b1110, 1'b0, 4'b0110);
`ifdef GATE_TT_CHECK_ERRCNT_EN
        @(posedge clk); #1;
        check("t6_ec1", 32'(ec1), 32'd1);
`endif
        run1(1'b0, 1'b0, d);
        final1("t2b", d, 4'b1110, 1'b0, 4'b0110);

        // AND gate with output corrupted except in sample cycles
        mode = 2;
        run1(1'b0, 1'b0, d);
        final1("glitch", d, 4'b1000, 1'b1, 4'b0000);
        mode = 0;
`ifdef GATE_TT_CHECK_ERRCNT_EN
        @(posedge clk); #1;
        check("t6_ec2", 32'(ec1), 32'd2);
`endif

        // T3: extra start pulses during a run are ignored
        run1(1'b1, 1'b0, d);
        final1("t3", d, 4'b1000, 1'b1, 4'b0000);
        ndone = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            if (done1) ndone++;
        end
        check("t3_no_2nd_done", 32'(ndone), 32'd0);
        check("t3_idle_busy", 32'(busy1), 32'd0);
`ifdef GATE_TT_CHECK_ERRCNT_EN
        check("t6_ec_stay", 32'(ec1), 32'd2);
`endif

        // Start held high: one IDLE cycle between DONE and next run
        run1(1'b0, 1'b1, d);
        final1("hold", d, 4'b1000, 1'b1, 4'b0000);
        @(posedge clk); #1;
        check("hold_idle_busy", 32'(busy1), 32'd0);
        check("hold_idle_done", 32'(done1), 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        check("hold_rerun_busy", 32'(busy1), 32'd1);
        check("hold_rerun_pass", 32'(pass1), 32'd0);
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done1) begin
                ndone = 1;
                break;
            end
        end
        check("hold_rerun_done", 32'(ndone), 32'd1);
        @(posedge clk); #1;

        // T4: reset in cycle 6 of an OR run
        mode = 1;
        @(posedge clk); #1;
        start = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        check("t4_pre_b", 32'(b1), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("t4_busy", 32'(busy1), 32'd0);
        check("t4_ab", 32'({a1, b1}), 32'd0);
        check("t4_rt", 32'(rt1), 32'd0);
        check("t4_outs", 32'({done1, pass1, fm1}), 32'd0);
`ifdef GATE_TT_CHECK_ERRCNT_EN
        check("t4_ec", 32'(ec1), 32'd0);
`endif
        mode = 0;
        run1(1'b0, 1'b0, d);
        final1("t4_fresh", d, 4'b1000, 1'b1, 4'b0000);

        // T5: SETTLE_CYCLES = 1 instance
        @(posedge clk); #1;
        start2 = 1'b1;
        d = -1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            start2 = 1'b0;
            if (k <= 9) begin
                ab_exp = (k <= 8) ? 2'((k - 1) / 2) : 2'd0;
                check($sformatf("t5_ab_c%0d", k), 32'({a2, b2}),
                      32'(ab_exp));
            end
            if (done2) begin
                d = k;
                break;
            end
        end
        check("t5_cyc", 32'(d), 32'd9);
        check("t5_rt", 32'(rt2), 32'b1000);
        check("t5_pass", 32'(pass2), 32'd1);
        check("t5_fm", 32'(fm2), 32'd0);
        check("t5_busy", 32'(busy2), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
